// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage core.
// Arbitrates memory wait, taken branch, load-use hazard and jump by fixed
// priority. It drives the per-stage write enables, the flush/bubble controls
// and the PC source select.
//
// state      | meaning
// -----------+------------------------------------------------------------
// INIT       | first cycle after reset: flush IF/ID, bubble ID/EX, PC held
// RUN        | normal issue, all events arbitrated
// LOAD_STALL | load advanced last cycle; load-use hazard ignored
// REDIRECT   | branch redirected last cycle; ID holds a NOP, jump/hazard ignored
// MEM_WAIT   | back end frozen until data memory completes
module pipeline_stall_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard,
    input  logic             id_jump,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout
);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_RUN        = 3'd1,
        S_LOAD_STALL = 3'd2,
        S_REDIRECT   = 3'd3,
        S_MEM_WAIT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             timeout_set;
    logic             lu_en;
    logic             jump_en;

    // State, wait counter, stall counter and sticky timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (!pc_we && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // Event arbitration, next state and pipeline control outputs.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_we    = 1'b0;
        // Hazard only honoured in plain RUN; jump also honoured after a load stall.
        lu_en   = (state == S_RUN);
        jump_en = (state == S_RUN) || (state == S_LOAD_STALL);

        case (state)
            S_INIT: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                state_nxt    = S_RUN;
            end
            S_MEM_WAIT: begin
                if (!mem_busy) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = S_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Counter parks here; the flag stays set until reset.
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_ONE;
                end
            end
            S_RUN, S_LOAD_STALL, S_REDIRECT: begin
                if (mem_busy) begin
                    state_nxt = S_MEM_WAIT;
                end else begin
                    ex_mem_we = 1'b1;
                    if (ex_branch_taken) begin
                        pc_we        = 1'b1;
                        pc_src       = 2'b10;
                        if_id_we     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_nxt    = S_REDIRECT;
                    end else if (load_use_hazard && lu_en) begin
                        id_ex_bubble = 1'b1;
                        state_nxt    = S_LOAD_STALL;
                    end else if (id_jump && jump_en) begin
                        pc_we       = 1'b1;
                        pc_src      = 2'b01;
                        if_id_we    = 1'b1;
                        if_id_flush = 1'b1;
                        state_nxt   = S_RUN;
                    end else begin
                        pc_we     = 1'b1;
                        if_id_we  = 1'b1;
                        state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                state_nxt    = S_INIT;
                wait_cnt_nxt = '0;
            end
        endcase
    end

endmodule
